// File: rtl/axi_xbar_pkg.sv
// rtl/axi_xbar_pkg.sv - shared response codes, target select and FSM state types for the AXI-Lite crossbar
package axi_xbar_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {TGT_NONE, TGT_CLINT, TGT_MEM} tgt_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ERR} rd_state_t;
    typedef enum logic [1:0] {WR_COLLECT, WR_FWD, WR_RESP, WR_ERR} wr_state_t;
endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite bundle, 32-bit address/data
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_addr_decode.sv
// rtl/axi_addr_decode.sv - maps an address onto the CLINT or memory window; CLINT wins on overlap
module axi_addr_decode
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h0000_0008,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic [31:0] addr,
    output tgt_t        tgt
);
    logic [31:0] clint_off;
    logic [31:0] mem_off;

    // Offsets wrap modulo 2^32, so addresses below a base fall out of range
    assign clint_off = addr - CLINT_BASE;
    assign mem_off   = addr - MEM_BASE;

    always_comb begin
        tgt = TGT_NONE;
        if (mem_off < MEM_SIZE)
            tgt = TGT_MEM;
        if (clint_off < CLINT_SIZE)
            tgt = TGT_CLINT;
    end
endmodule

// File: rtl/axi_lite_xbar.sv
// rtl/axi_lite_xbar.sv - 1-master / 2-slave AXI-Lite crossbar with independent read and write FSMs
module axi_lite_xbar
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h0000_0008,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
    input logic         clk,
    input logic         reset,
    axi_lite_if.slave   m,
    axi_lite_if.master  s_clint,
    axi_lite_if.master  s_mem
);
    tgt_t        ar_dec, aw_dec, rd_tgt, wr_tgt;
    rd_state_t   rd_state, rd_next;
    wr_state_t   wr_state, wr_next;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        aw_got, w_got, aw_sent, w_sent, aw_hs, w_hs, wr_done;

    axi_addr_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE),
                      .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE))
        u_ar_dec (.addr(m.araddr), .tgt(ar_dec));
    axi_addr_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE),
                      .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE))
        u_aw_dec (.addr(m.awaddr), .tgt(aw_dec));

    // Responses from whichever slave the latched transaction targets
    logic        t_arready, t_rvalid, t_awready, t_wready, t_bvalid;
    logic [31:0] t_rdata;
    logic [1:0]  t_rresp, t_bresp;
    logic        rd_clint, wr_clint;
    assign rd_clint  = (rd_tgt == TGT_CLINT);
    assign wr_clint  = (wr_tgt == TGT_CLINT);
    assign t_arready = rd_clint ? s_clint.arready : s_mem.arready;
    assign t_rvalid  = rd_clint ? s_clint.rvalid  : s_mem.rvalid;
    assign t_rdata   = rd_clint ? s_clint.rdata   : s_mem.rdata;
    assign t_rresp   = rd_clint ? s_clint.rresp   : s_mem.rresp;
    assign t_awready = wr_clint ? s_clint.awready : s_mem.awready;
    assign t_wready  = wr_clint ? s_clint.wready  : s_mem.wready;
    assign t_bvalid  = wr_clint ? s_clint.bvalid  : s_mem.bvalid;
    assign t_bresp   = wr_clint ? s_clint.bresp   : s_mem.bresp;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_tgt   <= TGT_NONE;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && m.arvalid) begin
                rd_addr <= m.araddr;
                rd_tgt  <= ar_dec;
            end
        end
    end

    logic        m_arready, m_rvalid, c_arvalid, c_rready, s_arvalid, s_rready;
    logic [31:0] m_rdata, c_araddr, s_araddr;
    logic [1:0]  m_rresp;

    always_comb begin
        rd_next   = rd_state;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = RESP_OKAY;
        c_arvalid = 1'b0;
        c_araddr  = '0;
        c_rready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                m_arready = 1'b1;
                if (m.arvalid)
                    rd_next = (ar_dec == TGT_NONE) ? RD_ERR : RD_ADDR;
            end
            RD_ADDR: begin
                if (rd_clint) begin
                    c_arvalid = 1'b1;
                    c_araddr  = rd_addr;
                end else begin
                    s_arvalid = 1'b1;
                    s_araddr  = rd_addr;
                end
                if (t_arready)
                    rd_next = RD_DATA;
            end
            RD_DATA: begin
                m_rvalid = t_rvalid;
                m_rdata  = t_rdata;
                m_rresp  = t_rresp;
                c_rready = rd_clint && m.rready;
                s_rready = !rd_clint && m.rready;
                if (t_rvalid && m.rready)
                    rd_next = RD_IDLE;
            end
            RD_ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = RESP_DECERR;
                if (m.rready)
                    rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    assign aw_hs = (wr_state == WR_COLLECT) && !aw_got && m.awvalid;
    assign w_hs  = (wr_state == WR_COLLECT) && !w_got && m.wvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_COLLECT;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
            wr_tgt   <= TGT_NONE;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            aw_sent  <= 1'b0;
            w_sent   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_got  <= 1'b1;
                wr_addr <= m.awaddr;
                wr_tgt  <= aw_dec;
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wr_data <= m.wdata;
                wr_strb <= m.wstrb;
            end
            if (wr_state == WR_FWD && !aw_sent && t_awready)
                aw_sent <= 1'b1;
            if (wr_state == WR_FWD && !w_sent && t_wready)
                w_sent <= 1'b1;
            if (wr_done) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                aw_sent <= 1'b0;
                w_sent  <= 1'b0;
            end
        end
    end

    logic        m_awready, m_wready, m_bvalid, t_awvalid, t_wvalid, t_bready;
    logic [1:0]  m_bresp;
    tgt_t        wr_tgt_now;

    always_comb begin
        wr_next    = wr_state;
        wr_done    = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        m_bresp    = RESP_OKAY;
        t_awvalid  = 1'b0;
        t_wvalid   = 1'b0;
        t_bready   = 1'b0;
        wr_tgt_now = aw_hs ? aw_dec : wr_tgt;
        case (wr_state)
            WR_COLLECT: begin
                m_awready = !aw_got;
                m_wready  = !w_got;
                if ((aw_got || aw_hs) && (w_got || w_hs))
                    wr_next = (wr_tgt_now == TGT_NONE) ? WR_ERR : WR_FWD;
            end
            WR_FWD: begin
                t_awvalid = !aw_sent;
                t_wvalid  = !w_sent;
                if ((aw_sent || t_awready) && (w_sent || t_wready))
                    wr_next = WR_RESP;
            end
            WR_RESP: begin
                m_bvalid = t_bvalid;
                m_bresp  = t_bresp;
                t_bready = m.bready;
                if (t_bvalid && m.bready) begin
                    wr_done = 1'b1;
                    wr_next = WR_COLLECT;
                end
            end
            WR_ERR: begin
                m_bvalid = 1'b1;
                m_bresp  = RESP_DECERR;
                if (m.bready) begin
                    wr_done = 1'b1;
                    wr_next = WR_COLLECT;
                end
            end
            default: wr_next = WR_COLLECT;
        endcase
    end

    logic c_wsel, s_wsel;
    assign c_wsel = (wr_state == WR_FWD) && wr_clint;
    assign s_wsel = (wr_state == WR_FWD) && !wr_clint;

    assign m.arready = m_arready;
    assign m.rvalid  = m_rvalid;
    assign m.rdata   = m_rdata;
    assign m.rresp   = m_rresp;
    assign m.awready = m_awready;
    assign m.wready  = m_wready;
    assign m.bvalid  = m_bvalid;
    assign m.bresp   = m_bresp;

    assign s_clint.arvalid = c_arvalid;
    assign s_clint.araddr  = c_araddr;
    assign s_clint.rready  = c_rready;
    assign s_clint.awvalid = c_wsel && t_awvalid;
    assign s_clint.awaddr  = c_wsel ? wr_addr : '0;
    assign s_clint.wvalid  = c_wsel && t_wvalid;
    assign s_clint.wdata   = c_wsel ? wr_data : '0;
    assign s_clint.wstrb   = c_wsel ? wr_strb : '0;
    assign s_clint.bready  = wr_clint && t_bready;

    assign s_mem.arvalid = s_arvalid;
    assign s_mem.araddr  = s_araddr;
    assign s_mem.rready  = s_rready;
    assign s_mem.awvalid = s_wsel && t_awvalid;
    assign s_mem.awaddr  = s_wsel ? wr_addr : '0;
    assign s_mem.wvalid  = s_wsel && t_wvalid;
    assign s_mem.wdata   = s_wsel ? wr_data : '0;
    assign s_mem.wstrb   = s_wsel ? wr_strb : '0;
    assign s_mem.bready  = !wr_clint && t_bready;
endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb/tb_axi_lite_xbar.sv - directed self-checking bench for axi_lite_xbar
module tb_axi_lite_xbar;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    axi_lite_if m_if();
    axi_lite_if c_if();
    axi_lite_if s_if();

    axi_lite_xbar dut (
        .clk     (clk),
        .reset   (reset),
        .m       (m_if),
        .s_clint (c_if),
        .s_mem   (s_if)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2000) @(posedge clk);
        chk("timeout_expired", 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1'b1;
        m_if.araddr = '0;  m_if.arvalid = 0; m_if.rready = 0;
        m_if.awaddr = '0;  m_if.awvalid = 0; m_if.wdata = '0;
        m_if.wstrb = '0;   m_if.wvalid = 0;  m_if.bready = 0;
        c_if.arready = 0;  c_if.rvalid = 0;  c_if.rdata = '0; c_if.rresp = '0;
        c_if.awready = 0;  c_if.wready = 0;  c_if.bvalid = 0; c_if.bresp = '0;
        s_if.arready = 0;  s_if.rvalid = 0;  s_if.rdata = '0; s_if.rresp = '0;
        s_if.awready = 0;  s_if.wready = 0;  s_if.bvalid = 0; s_if.bresp = '0;
        tick; tick;
        chk("rst_arready", m_if.arready, 1'b1);
        chk("rst_awready", m_if.awready, 1'b1);
        chk("rst_wready", m_if.wready, 1'b1);
        chk("rst_rvalid", m_if.rvalid, 1'b0);
        chk("rst_bvalid", m_if.bvalid, 1'b0);
        chk("rst_valids", {c_if.arvalid, c_if.awvalid, c_if.wvalid, s_if.arvalid, s_if.awvalid, s_if.wvalid}, 6'b0);
        reset = 1'b0;

        // CLINT read, slave stalls arready one cycle
        m_if.araddr = 32'ha000_0048; m_if.arvalid = 1;
        #1 chk("rd1_arready", m_if.arready, 1'b1);
        tick; m_if.arvalid = 0;
        #1 chk("rd1_c_arvalid", c_if.arvalid, 1'b1);
        chk("rd1_c_araddr", c_if.araddr, 32'ha000_0048);
        chk("rd1_m_arready", m_if.arready, 1'b0);
        tick;
        chk("rd1_c_arvalid_held", c_if.arvalid, 1'b1);
        c_if.arready = 1;
        tick; c_if.arready = 0;
        c_if.rvalid = 1; c_if.rdata = 32'h1234; c_if.rresp = 2'b00; m_if.rready = 1;
        #1 chk("rd1_rvalid", m_if.rvalid, 1'b1);
        chk("rd1_rdata", m_if.rdata, 32'h1234);
        chk("rd1_rresp", m_if.rresp, 2'b00);
        chk("rd1_c_rready", c_if.rready, 1'b1);
        chk("rd1_mem_quiet", s_if.arvalid, 1'b0);
        tick; c_if.rvalid = 0; m_if.rready = 0;
        #1 chk("rd1_done_rvalid", m_if.rvalid, 1'b0);
        chk("rd1_done_arready", m_if.arready, 1'b1);

        // unmapped read
        m_if.araddr = 32'h1000_0000; m_if.arvalid = 1;
        tick; m_if.arvalid = 0;
        #1 chk("rd2_rvalid", m_if.rvalid, 1'b1);
        chk("rd2_rdata", m_if.rdata, 32'h0);
        chk("rd2_rresp", m_if.rresp, 2'b11);
        chk("rd2_no_slave", {c_if.arvalid, s_if.arvalid}, 2'b00);
        tick;
        chk("rd2_rvalid_held", m_if.rvalid, 1'b1);
        m_if.rready = 1;
        tick; m_if.rready = 0;
        #1 chk("rd2_done", m_if.rvalid, 1'b0);

        // W two cycles ahead of AW, memory target, W accepted before AW downstream
        m_if.wdata = 32'hdeadbeef; m_if.wstrb = 4'hf; m_if.wvalid = 1;
        #1 chk("wr1_wready", m_if.wready, 1'b1);
        tick; m_if.wvalid = 0;
        #1 chk("wr1_wready_low", m_if.wready, 1'b0);
        chk("wr1_awready", m_if.awready, 1'b1);
        tick;
        m_if.awaddr = 32'h8000_0010; m_if.awvalid = 1;
        tick; m_if.awvalid = 0;
        #1 chk("wr1_s_awvalid", s_if.awvalid, 1'b1);
        chk("wr1_s_awaddr", s_if.awaddr, 32'h8000_0010);
        chk("wr1_s_wvalid", s_if.wvalid, 1'b1);
        chk("wr1_s_wdata", s_if.wdata, 32'hdeadbeef);
        chk("wr1_s_wstrb", s_if.wstrb, 4'hf);
        chk("wr1_c_quiet", {c_if.awvalid, c_if.wvalid, c_if.awaddr}, 34'h0);
        s_if.wready = 1;
        tick; s_if.wready = 0;
        #1 chk("wr1_wvalid_drop", s_if.wvalid, 1'b0);
        chk("wr1_awvalid_held", s_if.awvalid, 1'b1);
        s_if.awready = 1;
        tick; s_if.awready = 0;
        s_if.bvalid = 1; s_if.bresp = 2'b00; m_if.bready = 1;
        #1 chk("wr1_bvalid", m_if.bvalid, 1'b1);
        chk("wr1_bresp", m_if.bresp, 2'b00);
        chk("wr1_s_bready", s_if.bready, 1'b1);
        tick; s_if.bvalid = 0; m_if.bready = 0;
        #1 chk("wr1_done", {m_if.bvalid, m_if.awready, m_if.wready}, 3'b011);

        // AW and W together to the CLINT, SLVERR passes through
        m_if.awaddr = 32'ha000_004c; m_if.awvalid = 1;
        m_if.wdata = 32'h55; m_if.wstrb = 4'h3; m_if.wvalid = 1;
        tick; m_if.awvalid = 0; m_if.wvalid = 0;
        #1 chk("wr2_c_awvalid", c_if.awvalid, 1'b1);
        chk("wr2_c_awaddr", c_if.awaddr, 32'ha000_004c);
        chk("wr2_c_wdata", c_if.wdata, 32'h55);
        chk("wr2_mem_quiet", {s_if.awvalid, s_if.wvalid}, 2'b00);
        c_if.awready = 1; c_if.wready = 1;
        tick; c_if.awready = 0; c_if.wready = 0;
        c_if.bvalid = 1; c_if.bresp = 2'b10;
        #1 chk("wr2_bvalid", m_if.bvalid, 1'b1);
        chk("wr2_bresp", m_if.bresp, 2'b10);
        chk("wr2_c_bready_low", c_if.bready, 1'b0);
        m_if.bready = 1;
        #1 chk("wr2_c_bready", c_if.bready, 1'b1);
        tick; c_if.bvalid = 0; m_if.bready = 0;
        #1 chk("wr2_done", m_if.bvalid, 1'b0);

        // one byte past the CLINT window is unmapped
        m_if.awaddr = 32'ha000_0050; m_if.awvalid = 1;
        m_if.wdata = 32'h1; m_if.wvalid = 1;
        tick; m_if.awvalid = 0; m_if.wvalid = 0;
        #1 chk("wr3_bvalid", m_if.bvalid, 1'b1);
        chk("wr3_bresp", m_if.bresp, 2'b11);
        chk("wr3_no_slave", {c_if.awvalid, c_if.wvalid, s_if.awvalid, s_if.wvalid}, 4'b0);
        m_if.bready = 1;
        tick; m_if.bready = 0;
        #1 chk("wr3_done", m_if.bvalid, 1'b0);

        // memory read with rready held low for 5 cycles
        m_if.araddr = 32'h8000_0100; m_if.arvalid = 1;
        tick; m_if.arvalid = 0;
        s_if.arready = 1;
        #1 chk("rd3_s_araddr", s_if.araddr, 32'h8000_0100);
        tick; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'hcafef00d; s_if.rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rd3_stall_rvalid", m_if.rvalid, 1'b1);
            chk("rd3_stall_rdata", m_if.rdata, 32'hcafef00d);
            chk("rd3_stall_rready", s_if.rready, 1'b0);
            chk("rd3_stall_arready", m_if.arready, 1'b0);
            tick;
        end
        m_if.rready = 1;
        #1 chk("rd3_s_rready", s_if.rready, 1'b1);
        tick; m_if.rready = 0; s_if.rvalid = 0;
        #1 chk("rd3_done_arready", m_if.arready, 1'b1);

        // reset while in RD_ADDR abandons the read
        m_if.araddr = 32'h8000_0200; m_if.arvalid = 1;
        tick; m_if.arvalid = 0;
        #1 chk("rd4_s_arvalid", s_if.arvalid, 1'b1);
        reset = 1;
        tick; reset = 0;
        s_if.rvalid = 1; s_if.rdata = 32'hbad;
        #1 chk("rd4_rst_arvalid", s_if.arvalid, 1'b0);
        chk("rd4_rst_arready", m_if.arready, 1'b1);
        chk("rd4_rst_rvalid", m_if.rvalid, 1'b0);
        s_if.rvalid = 0;
        m_if.araddr = 32'h8000_0300; m_if.arvalid = 1;
        tick; m_if.arvalid = 0;
        #1 chk("rd5_s_araddr", s_if.araddr, 32'h8000_0300);
        s_if.arready = 1;
        tick; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'h77; s_if.rresp = 2'b00; m_if.rready = 1;
        #1 chk("rd5_rdata", m_if.rdata, 32'h77);
        chk("rd5_rvalid", m_if.rvalid, 1'b1);
        tick; s_if.rvalid = 0; m_if.rready = 0;
        #1 chk("rd5_done", m_if.rvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_xbar.md
Name: axi_lite_xbar

Overview:
- 1-master, 2-slave AXI4-Lite crossbar between the core's LSU/IFU arbiter (master side) and the CLINT and main-memory slaves.
- Decodes each read and write address and forwards the transaction to the selected slave.
- Returns DECERR for unmapped addresses without touching any slave.
- Read and write paths are independent; each allows one outstanding transaction.

Parameters:
- CLINT_BASE, 32'ha000_0048, CLINT window base.
- CLINT_SIZE, 32'h0000_0008, CLINT window size in bytes.
- MEM_BASE, 32'h8000_0000, memory window base.
- MEM_SIZE, 32'h0800_0000, memory window size in bytes.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- m  axi_lite_if.slave  intf (32b addr/data, 4b wstrb, 2b resp)  upstream master side
- s_clint  axi_lite_if.master  intf  downstream CLINT
- s_mem  axi_lite_if.master  intf  downstream memory

Behaviour:
- Decode: hit_x = (addr - X_BASE) < X_SIZE, 32-bit unsigned with wrap. If both windows hit, CLINT wins. If neither hits, the access is unmapped.
- Idle outputs:
  - Slave ports not currently selected drive all valids, rready and bready at 0, and addr/wdata/wstrb at 0.
  - The m port drives rvalid=0 and bvalid=0 outside the response states.
- Reset: both FSMs go to idle; m.arready=1, m.awready=1, m.wready=1; every valid output is 0; latched flags clear.
- Reset mid-transaction abandons it: no pending response is delivered, and slaves see their valid drop the cycle after reset.
- Read FSM, states RD_IDLE, RD_ADDR, RD_DATA, RD_ERR:
  - RD_IDLE: m.arready=1. On m.arvalid, latch araddr and the target select, then go to RD_ADDR if mapped, else RD_ERR.
  - RD_ADDR: target.arvalid=1 and target.araddr=latched address, held stable. On target.arready, go to RD_DATA. Minimum one cycle, because the request is registered.
  - RD_DATA: m.rvalid=target.rvalid, m.rdata=target.rdata, m.rresp=target.rresp, target.rready=m.rready. On the handshake, go to RD_IDLE.
  - RD_ERR: m.rvalid=1, rdata=0, rresp=2'b11. On m.rready, go to RD_IDLE.
  - Minimum AR-to-R latency is 2 cycles plus slave latency.
- Write FSM, states WR_COLLECT, WR_FWD, WR_RESP, WR_ERR:
  - WR_COLLECT: m.awready=!aw_got and m.wready=!w_got. AW and W are accepted in either order or in the same cycle, latching awaddr, wdata and wstrb. When both are latched, go to WR_FWD if mapped, else WR_ERR.
  - WR_FWD: target.awvalid=!aw_sent and target.wvalid=!w_sent, each dropping independently after its handshake. When both are sent, go to WR_RESP.
  - WR_RESP: forward B both ways, with bresp passed through unchanged (the CLINT's 2'b10 reaches the master). On the handshake, clear the flags and go to WR_COLLECT.
  - WR_ERR: m.bvalid=1, bresp=2'b11. On m.bready, go to WR_COLLECT.
- Concurrency and ordering:
  - A read and a write in flight simultaneously, to the same or different slaves, are legal. Their responses are independent, with no ordering between channels.
  - Backpressure: every m-side valid stays asserted with stable payload until its ready.

Decomposition:
- Package axi_xbar_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - typedef enum tgt_t {TGT_NONE, TGT_CLINT, TGT_MEM};
  - the read and write state enums.
- Sub-module: one combinational axi_addr_decode (addr to tgt_t), instantiated twice, once for AR and once for AW.

Test Plan:
- AR 0xa000_0048 with the CLINT returning rdata 0x1234 -> s_clint.arvalid asserts exactly one cycle after the m handshake with araddr 0xa000_0048; m sees rdata 0x1234, rresp 00; s_mem is never valid.
- AR 0x1000_0000 (unmapped) -> m.rvalid with rdata 0, rresp 11; neither slave sees arvalid.
- W (data 0xdeadbeef, strb 4'hf) two cycles before AW 0x8000_0010 -> s_mem receives awaddr 0x8000_0010 and wdata 0xdeadbeef; m.bresp 00.
- AW/W to 0xa000_004c -> forwarded to the CLINT; m.bresp 10 is propagated unchanged.
- m.rready held low 5 cycles during RD_DATA -> m.rvalid/rdata stable, s_mem.rready=0, m.arready=0 until the handshake.
- Reset asserted in RD_ADDR -> the next cycle shows all valids 0 and m.arready=1; a subsequent read completes normally.
